// File: rtl/sig_gen.sv
// Square-wave stimulus generator with programmable high/low phase lengths and burst count.
// Optional macro SIG_GEN_STOP_ALIGN_EN: stop while busy completes the current period before idling.
module sig_gen #(
   parameter logic [31:0] DEFAULT_HIGH_CNT = 32'd99,
   parameter logic [31:0] DEFAULT_LOW_CNT  = 32'd99
) (
   input  logic        sys_clk,
   input  logic        rst_n,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic [31:0] cfg_high_cnt,
   input  logic [31:0] cfg_low_cnt,
   input  logic [31:0] cfg_pulse_num,
   input  logic        start,
   input  logic        stop,
   output logic        sig_out,
   output logic        busy,
   output logic        done,
   output logic [31:0] pulse_cnt
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HIGH = 2'd1, ST_LOW = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [31:0] phase_cnt_q, phase_cnt_d;
   logic [31:0] pulse_cnt_q, pulse_cnt_d;
   logic [31:0] high_cnt_q, high_cnt_d;
   logic [31:0] low_cnt_q, low_cnt_d;
   logic [31:0] pulse_num_q, pulse_num_d;
   logic        sig_out_q, sig_out_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        cfg_ready_q, cfg_ready_d;
   logic        phase_end_s, burst_end_s, abort_s, align_stop_s;

`ifdef SIG_GEN_STOP_ALIGN_EN
   logic stop_pend_q, stop_pend_d;

   assign abort_s      = 1'b0;
   assign align_stop_s = stop_pend_q | stop;

   // Pending stop survives until the period closes; start+stop in IDLE never arms it.
   always_comb begin
      stop_pend_d = stop_pend_q;
      if (state_d == ST_IDLE) begin
         stop_pend_d = 1'b0;
      end else if (stop && (state_q != ST_IDLE)) begin
         stop_pend_d = 1'b1;
      end else begin
         stop_pend_d = stop_pend_q;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         stop_pend_q <= 1'b0;
      end else begin
         stop_pend_q <= stop_pend_d;
      end
   end
`else
   assign abort_s      = stop;
   assign align_stop_s = 1'b0;
`endif

   assign phase_end_s = (state_q == ST_HIGH) ? (phase_cnt_q == high_cnt_q)
                                             : (phase_cnt_q == low_cnt_q);
   assign burst_end_s = (pulse_num_q != 32'd0) && (pulse_cnt_q == pulse_num_q);

   // State and datapath registers.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         phase_cnt_q <= 32'd0;
         pulse_cnt_q <= 32'd0;
         high_cnt_q  <= DEFAULT_HIGH_CNT;
         low_cnt_q   <= DEFAULT_LOW_CNT;
         pulse_num_q <= 32'd0;
         sig_out_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cfg_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         phase_cnt_q <= phase_cnt_d;
         pulse_cnt_q <= pulse_cnt_d;
         high_cnt_q  <= high_cnt_d;
         low_cnt_q   <= low_cnt_d;
         pulse_num_q <= pulse_num_d;
         sig_out_q   <= sig_out_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cfg_ready_q <= cfg_ready_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start && !stop) state_d = ST_HIGH;
            else                state_d = ST_IDLE;
         end
         ST_HIGH: begin
            if (abort_s)          state_d = ST_IDLE;
            else if (phase_end_s) state_d = ST_LOW;
            else                  state_d = ST_HIGH;
         end
         ST_LOW: begin
            if (abort_s)                                  state_d = ST_IDLE;
            else if (phase_end_s && (burst_end_s || align_stop_s)) state_d = ST_IDLE;
            else if (phase_end_s)                         state_d = ST_HIGH;
            else                                          state_d = ST_LOW;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs, counters and configuration capture, all registered from the next state.
   always_comb begin
      sig_out_d   = (state_d == ST_HIGH);
      busy_d      = (state_d != ST_IDLE);
      cfg_ready_d = (state_d == ST_IDLE);
      done_d      = (state_q == ST_LOW) && phase_end_s && burst_end_s && !abort_s && !align_stop_s;

      if ((state_d == ST_IDLE) || (state_d != state_q)) begin
         phase_cnt_d = 32'd0;
      end else begin
         phase_cnt_d = phase_cnt_q + 32'd1;
      end

      if ((state_q == ST_IDLE) && (state_d == ST_HIGH)) begin
         pulse_cnt_d = 32'd1;
      end else if ((state_q == ST_LOW) && (state_d == ST_HIGH) && (pulse_cnt_q != 32'hFFFF_FFFF)) begin
         pulse_cnt_d = pulse_cnt_q + 32'd1;
      end else begin
         pulse_cnt_d = pulse_cnt_q;
      end

      if (cfg_valid && cfg_ready_q) begin
         high_cnt_d  = cfg_high_cnt;
         low_cnt_d   = cfg_low_cnt;
         pulse_num_d = cfg_pulse_num;
      end else begin
         high_cnt_d  = high_cnt_q;
         low_cnt_d   = low_cnt_q;
         pulse_num_d = pulse_num_q;
      end
   end

   assign sig_out   = sig_out_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign cfg_ready = cfg_ready_q;
   assign pulse_cnt = pulse_cnt_q;

endmodule

// File: doc/sig_gen.md
SIG_GEN -- requirements
Module: sig_gen

Interface
REQ-001 The block SHALL have the parameter DEFAULT_HIGH_CNT, default 99, giving the reset value of the high-phase length in sys_clk cycles minus one.
REQ-002 The block SHALL have the parameter DEFAULT_LOW_CNT, default 99, giving the reset value of the low-phase length in sys_clk cycles minus one.
REQ-003 The block SHALL have port sys_clk, input, 1 bit: the single clock, 200 MHz, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port cfg_valid, input, 1 bit: a configuration word is present.
REQ-006 The block SHALL have port cfg_ready, output, 1 bit: the block accepts configuration (high only in IDLE).
REQ-007 The block SHALL have port cfg_high_cnt, input, 32 bits: high-phase length in cycles, encoded as N-1.
REQ-008 The block SHALL have port cfg_low_cnt, input, 32 bits: low-phase length in cycles, encoded as N-1.
REQ-009 The block SHALL have port cfg_pulse_num, input, 32 bits: number of periods per burst; 0 means continuous.
REQ-010 The block SHALL have port start, input, 1 bit: single-cycle request to begin output.
REQ-011 The block SHALL have port stop, input, 1 bit: single-cycle request to end output.
REQ-012 The block SHALL have port sig_out, output, 1 bit: registered square-wave test stimulus for the frequency meter's sig_in.
REQ-013 The block SHALL have port busy, output, 1 bit: the block is in HIGH or LOW.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse when a finite burst completes.
REQ-015 The block SHALL have port pulse_cnt, output, 32 bits: number of sig_out rising edges since the last accepted start.

Function
REQ-016 The block SHALL latch the cfg_* inputs into internal registers on any cycle with cfg_valid && cfg_ready; latched values take effect at the next accepted start.
REQ-017 The block SHALL implement the states IDLE, HIGH and LOW; sig_out = 1 in HIGH and 0 otherwise; busy = (state != IDLE).
REQ-018 A start in IDLE (with stop low) SHALL move the block to HIGH on the next edge, clear pulse_cnt and then increment it, so pulse_cnt reads 1 in the first HIGH cycle.
REQ-019 HIGH SHALL last high_cnt+1 cycles, then transition to LOW; LOW SHALL last low_cnt+1 cycles; period = high_cnt+low_cnt+2 cycles.
REQ-020 At the end of LOW, the block SHALL go to HIGH and increment pulse_cnt, unless pulse_num != 0 and pulse_cnt == pulse_num, in which case it SHALL go to IDLE with done = 1 for exactly that first IDLE cycle.
REQ-021 start SHALL be ignored while busy; cfg_valid SHALL be ignored while busy, with cfg_ready = 0.
REQ-022 start and stop asserted in the same IDLE cycle SHALL leave the block in IDLE; stop alone in IDLE SHALL have no effect.
REQ-023 Without SIG_GEN_STOP_ALIGN_EN, stop while busy SHALL force IDLE on the next edge, with sig_out = 0, no done pulse, and pulse_cnt held.
REQ-024 The phase counter and pulse_cnt SHALL be 32 bits; the phase counter SHALL compare for equality against the latched value (no wrap); pulse_cnt SHALL saturate at 32'hFFFFFFFF in continuous mode.

Reset
REQ-025 While rst_n is low, the block SHALL hold state = IDLE, sig_out = 0, busy = 0, done = 0, pulse_cnt = 0, cfg_ready = 1, phase counter = 0, high_cnt = DEFAULT_HIGH_CNT, low_cnt = DEFAULT_LOW_CNT and pulse_num = 0.
REQ-026 Reset asserted mid-burst SHALL clear all outputs immediately (asynchronously), and the block SHALL restart only on a new start after reset release.

Configuration
REQ-027 With the macro SIG_GEN_STOP_ALIGN_EN defined, stop while busy SHALL set a pending flag, and the block SHALL enter IDLE only at the end of the current LOW phase (completing the period), with no done pulse.
REQ-028 Without SIG_GEN_STOP_ALIGN_EN, stop SHALL abort immediately as in REQ-023, and no pending-flag logic SHALL be present.

Verification
REQ-029 Reset, then start at cycle N with defaults -> sig_out = 1 for cycles N+1..N+100 and 0 for cycles N+101..N+200, repeating (1 MHz); pulse_cnt = 2 at cycle N+201.
REQ-030 cfg high=1, low=2, pulse_num=4, then start -> 4 periods of 2 high / 3 low cycles; done = 1 for one cycle, 20 cycles after the first HIGH cycle; busy falls in that cycle; pulse_cnt = 4 is held.
REQ-031 cfg high=0, low=0, pulse_num=0 -> sig_out toggles every cycle (100 MHz); busy stays 1 until stop.
REQ-032 stop in the 3rd HIGH cycle of the default config -> without the macro, sig_out = 0 and busy = 0 on the next cycle and done stays 0; with the macro, sig_out completes 100 low cycles, then the block goes to IDLE with done = 0.
REQ-033 cfg_valid with high=5 while busy -> cfg_ready = 0 and the period is unchanged; start and stop together in IDLE -> busy stays 0.
REQ-034 rst_n pulsed low during a HIGH phase -> sig_out, busy and pulse_cnt read 0 before the next sys_clk edge, and cfg_ready = 1.
